// File: rtl/stopwatch_lap.sv
// Stopwatch/timer core: prescaled up-count with wrap at MAX or countdown to zero,
// with pause/resume, clear, lap capture and an LED mux for count or lap.
module stopwatch_lap #(
    parameter int DIV   = 100_000_000,
    parameter int CNT_W = 8,
    parameter int MAX   = 2**CNT_W-1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic             down,
    input  logic [CNT_W-1:0] load_val,
    input  logic             lap,
    input  logic             show_lap,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] led,
    output logic             tick,
    output logic             running,
    output logic             done,
    output logic             lap_valid
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [PW-1:0]    r_presc;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_lap;
    logic             r_lap_valid;
    logic             r_tick;
    logic             r_down;

    logic             w_wrap;
    logic             w_at_max;

    assign w_wrap   = (r_presc == PW'(DIV-1));
    assign w_at_max = (r_count == CNT_W'(MAX));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state     <= S_IDLE;
            r_presc     <= '0;
            r_count     <= '0;
            r_lap       <= '0;
            r_lap_valid <= 1'b0;
            r_tick      <= 1'b0;
            r_down      <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_down  <= down;
                        r_presc <= '0;
                        if (down) begin
                            r_count <= load_val;
                            r_state <= (load_val == '0) ? S_DONE : S_RUN;
                        end else begin
                            r_count <= '0;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // Lap captures the pre-update value even when a tick coincides.
                    if (lap) begin
                        r_lap       <= r_count;
                        r_lap_valid <= 1'b1;
                    end
                    if (pause) begin
                        r_state <= S_PAUSE;
                    end else if (w_wrap) begin
                        r_presc <= '0;
                        r_tick  <= 1'b1;
                        if (r_down) begin
                            r_count <= r_count - CNT_W'(1);
                            if (r_count == CNT_W'(1)) begin
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_count <= w_at_max ? '0 : r_count + CNT_W'(1);
                        end
                    end else begin
                        r_presc <= r_presc + PW'(1);
                    end
                end
                S_PAUSE: begin
                    if (lap) begin
                        r_lap       <= r_count;
                        r_lap_valid <= 1'b1;
                    end
                    if (start) begin
                        r_state <= S_RUN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign count     = r_count;
    assign led       = show_lap ? r_lap : r_count;
    assign tick      = r_tick;
    assign running   = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign lap_valid = r_lap_valid;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Scoreboard bench for stopwatch_lap: directed scenarios then random pulses,
// checked each cycle against a time-based behavioural model.
module tb_stopwatch_lap;

    localparam int DIV   = 4;
    localparam int CNT_W = 4;
    localparam int MAX   = 9;

    logic             clk;
    logic             rst, start, pause, clear, down, lap, show_lap;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] count, led;
    logic             tick, running, done, lap_valid;

    stopwatch_lap #(.DIV(DIV), .CNT_W(CNT_W), .MAX(MAX)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
        .down(down), .load_val(load_val), .lap(lap), .show_lap(show_lap),
        .count(count), .led(led), .tick(tick), .running(running),
        .done(done), .lap_valid(lap_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int led;
        int tick;
        int run;
        int dn;
        int lapv;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc_no   = 0;

    // Model: the watch is in exactly one of idle / running / paused / finished;
    // elapsed counts cycles spent running inside the current tick period.
    int m_cnt = 0, m_lap = 0, m_lapv = 0, m_elapsed = 0;
    int m_running = 0, m_paused = 0, m_finished = 0, m_countdown = 0;

    task automatic model_step(bit rs, bit cl, bit st, bit pa, bit la, bit dn, int lv, bit sl);
        exp_t e;
        int   tk;
        tk = 0;
        if (rs || cl) begin
            m_cnt = 0; m_lap = 0; m_lapv = 0; m_elapsed = 0;
            m_running = 0; m_paused = 0; m_finished = 0; m_countdown = 0;
        end else if (m_running) begin
            if (la) begin m_lap = m_cnt; m_lapv = 1; end
            if (pa) begin
                m_running = 0; m_paused = 1;
            end else begin
                m_elapsed++;
                if (m_elapsed == DIV) begin
                    m_elapsed = 0;
                    tk = 1;
                    if (m_countdown) begin
                        m_cnt = m_cnt - 1;
                        if (m_cnt == 0) begin m_running = 0; m_finished = 1; end
                    end else begin
                        m_cnt = (m_cnt + 1) % (MAX + 1);
                    end
                end
            end
        end else if (m_paused) begin
            if (la) begin m_lap = m_cnt; m_lapv = 1; end
            if (st) begin m_paused = 0; m_running = 1; end
        end else if (st) begin
            m_countdown = dn;
            m_elapsed   = 0;
            m_cnt       = dn ? lv : 0;
            m_finished  = (dn && lv == 0);
            m_running   = !m_finished;
        end
        e.cnt  = m_cnt;
        e.led  = sl ? m_lap : m_cnt;
        e.tick = tk;
        e.run  = m_running;
        e.dn   = m_finished;
        e.lapv = m_lapv;
        q.push_back(e);
    endtask

    task automatic drive(bit rs, bit cl, bit st, bit pa, bit la, bit dn, int lv, bit sl);
        rst = rs; clear = cl; start = st; pause = pa; lap = la; down = dn;
        load_val = CNT_W'(lv); show_lap = sl;
        model_step(rs, cl, st, pa, la, dn, lv, sl);
        @(negedge clk);
    endtask

    task automatic idle(int n, bit sl);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0, sl);
    endtask

    task automatic chk(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc_no, got, exp);
        end
    endtask

    // Monitor: every clock edge the DUT presents a new output set; pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("count",     int'(count),     e.cnt);
                chk("led",       int'(led),       e.led);
                chk("tick",      int'(tick),      e.tick);
                chk("running",   int'(running),   e.run);
                chk("done",      int'(done),      e.dn);
                chk("lap_valid", int'(lap_valid), e.lapv);
                $display("cyc=%0d count=%0d led=%0d tick=%0d run=%0d done=%0d lapv=%0d",
                         cyc_no, count, led, tick, running, done, lap_valid);
                cyc_no++;
            end
        end
    end

    initial begin
        rst = 1; clear = 0; start = 0; pause = 0; lap = 0; down = 0;
        load_val = '0; show_lap = 0;

        // Reset with random inputs on the other pins
        repeat (2) drive(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                         $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
                         $urandom_range(0, 1));

        // Up count through the wrap at MAX
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        idle(44, 0);

        // Pause at cycle 7, resume at cycle 20
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        idle(6, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        idle(12, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        idle(8, 0);

        // Countdown from 3, then restart with load 0
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 1, 3, 0);
        idle(15, 0);
        drive(0, 0, 1, 0, 0, 1, 0, 0);
        idle(3, 0);

        // Lap in the tick cycle at count 4
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        idle(19, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 1);
        idle(10, 1);
        idle(4, 0);

        // Clear together with start and lap at count 6
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        idle(25, 0);
        drive(0, 1, 1, 0, 1, 0, 0, 1);
        idle(3, 1);

        // Reset mid-countdown, then a fresh run
        drive(0, 0, 1, 0, 0, 1, 7, 0);
        idle(10, 0);
        drive(1, 0, 1, 0, 1, 1, 5, 0);
        idle(2, 0);
        drive(0, 0, 1, 0, 0, 1, 2, 0);
        idle(10, 0);

        // Random pulses
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 59) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1),
                  ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15),
                  $urandom_range(0, 1));
        end
        idle(2, 0);

        repeat (4) @(posedge clk);
        #2;
        chk("queue_drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_lap.md
# stopwatch_lap

Parametrised stopwatch/timer core with an internal tick prescaler. It counts up with wrap, or counts down to zero from a loaded value. It supports pause/resume, synchronous clear and a lap-capture register, and drives an LED display vector that shows either the live count or the captured lap. It sits between the debounced board buttons and the LED bank, and replaces the separate pulse/fsm/leds stopwatch chain.

## Interface
- DIV, 100_000_000: clock cycles per count tick; legal range DIV ≥ 2.
- CNT_W, 8: width of count, lap and LED vectors.
- MAX, 2**CNT_W-1: up-mode terminal value; the next value after MAX is 0. Legal range 1 ≤ MAX ≤ 2**CNT_W-1.

- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse: start, resume or restart.
- pause  in  1  one-cycle pulse: pause while running.
- clear  in  1  one-cycle pulse: return to idle, zero everything.
- down  in  1  mode select, sampled only when start is accepted in IDLE or DONE (1 = countdown).
- load_val  in  CNT_W  countdown start value, sampled together with down.
- lap  in  1  one-cycle pulse: capture count into the lap register.
- show_lap  in  1  level: 1 = led shows lap register, 0 = led shows count.
- count  out  CNT_W  live count.
- led  out  CNT_W  combinational: show_lap ? lap_reg : count.
- tick  out  1  one-cycle pulse, high in the first cycle a new count value is visible.
- running  out  1  high in RUN.
- done  out  1  high in DONE.
- lap_valid  out  1  lap register holds a capture since the last clear or reset.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset and clear go to IDLE.
- Input priority: rst > clear > state-specific inputs. In each state only the inputs listed for it act; all others are ignored.
- IDLE
  - start → RUN, prescaler = 0, mode latched from down.
  - If down = 1: count ← load_val. If load_val = 0, go to DONE instead of RUN.
- RUN
  - Prescaler advances 0..DIV-1 in every RUN cycle without pause.
  - At prescaler = DIV-1: prescaler ← 0, count updates, tick fires.
  - Up mode: count ← (count == MAX) ? 0 : count+1.
  - Down mode: count ← count-1. The step 1→0 enters DONE.
  - pause → PAUSE. The prescaler and count are frozen and no tick occurs in that cycle, even when the prescaler = DIV-1.
- PAUSE
  - start → RUN; the prescaler resumes from its held value.
  - pause is ignored.
- DONE
  - count = 0.
  - start reloads like IDLE, using the current down and load_val.
- lap
  - Accepted in RUN and PAUSE: lap_reg ← the count value present in that cycle (pre-update if a tick coincides); lap_valid ← 1.
  - Ignored in IDLE and DONE.
- clear or rst
  - count, prescaler, lap_reg, lap_valid and tick ← 0.
  - State ← IDLE.
  - running and done ← 0.
- Arithmetic: all count arithmetic is modulo CNT_W bits. Up mode never exceeds MAX. Down mode never wraps below 0.

## Timing
- All outputs except led are registered. led follows show_lap, lap_reg and count combinationally.
- Start accepted in cycle N: running = 1 from cycle N+1. The first count change is visible in cycle N+DIV+1; later changes follow every DIV cycles.
- tick is high for exactly one cycle, aligned with the new count value.
- Entry to DONE: done = 1 and running = 0 in the same cycle that count = 0 becomes visible, together with tick.
- Pause in cycle P: running = 0 from P+1.
- Resume in cycle R with held prescaler value h: the next count change is visible in cycle R+(DIV-h)+1.
- clear or rst in cycle C: all outputs at reset values in cycle C+1, including a clear that coincides with start, tick or lap.

## Test plan
All scenarios use DIV=4, CNT_W=4, MAX=9.
- **Reset:** rst high 2 cycles with random inputs → count = 0, led = 0, tick = 0, running = 0, done = 0, lap_valid = 0.
- **Up count and wrap:** start at cycle 0 (down = 0) → count = 1 at cycle 5, 2 at 9, … 9 at 37, 0 at 41. tick is high only in cycles 5, 9, …, 41. running = 1 from cycle 1.
- **Pause and resume:** start at cycle 0, pause at cycle 7 (count = 1, prescaler = 2), start at cycle 20 → count holds 1 through cycle 22, becomes 2 at cycle 23, no tick during PAUSE.
- **Countdown:** down = 1, load_val = 3, start at cycle 0 → count = 3 at cycle 1, 2 at 5, 1 at 9, 0 at 13 with done = 1 and running = 0 at 13. A later start with load_val = 0 → done stays 1 and count = 0 one cycle later.
- **Lap:** up mode, lap in a tick cycle where the prescaler = 3 with count = 4 → lap_reg = 4, lap_valid = 1, count = 5. With show_lap = 1, led stays 4 while count advances; with show_lap = 0, led = count.
- **Clear priority and mid-run reset:** clear together with start and lap while running at count = 6 → next cycle IDLE with all zero and lap_valid = 0. rst mid-countdown → IDLE, done = 0, a subsequent start behaves as a fresh run.
